// File: rtl/tis_pkg.sv
// Shared definitions for the TIS-100 node: widths, PC opcodes, PC FSM states.
// Also used by op_decode, so the widths and opcode values must stay in sync with it.
package tis_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 11;

    localparam logic [3:0] PC_NEXT = 4'd0;
    localparam logic [3:0] PC_HOLD = 4'd1;
    localparam logic [3:0] PC_JMP  = 4'd2;
    localparam logic [3:0] PC_JEZ  = 4'd3;
    localparam logic [3:0] PC_JNZ  = 4'd4;
    localparam logic [3:0] PC_JGZ  = 4'd5;
    localparam logic [3:0] PC_JLZ  = 4'd6;
    localparam logic [3:0] PC_JRO  = 4'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pc_state_e;

    // True when the op transfers control to const: JMP always, conditionals by acc sign.
    function automatic logic jump_taken(input logic [3:0]               op,
                                        input logic signed [DATA_W-1:0] acc);
        logic r;
        r = 1'b0;
        case (op)
            PC_JMP:  r = 1'b1;
            PC_JEZ:  r = (acc == '0);
            PC_JNZ:  r = (acc != '0);
            PC_JGZ:  r = (acc > 0);
            PC_JLZ:  r = (acc < 0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tis_pc_next.sv
// Next-address computation for the PC stage (purely combinational, 0 cycles).
// No handshake: the caller decides whether the result is committed.
module tis_pc_next
    import tis_pkg::*;
(
    input  logic [ADDR_W-1:0]        i_pc,
    input  logic [ADDR_W-1:0]        i_len,
    input  logic [3:0]               i_pc_instr,
    input  logic signed [DATA_W-1:0] i_const,
    input  logic signed [DATA_W-1:0] i_acc,
    input  logic signed [DATA_W-1:0] i_src_val,
    output logic [ADDR_W-1:0]        o_next
);

    logic [ADDR_W-1:0]        w_last;
    logic [ADDR_W-1:0]        w_seq;
    logic [ADDR_W-1:0]        w_tgt;
    logic [ADDR_W-1:0]        w_jmp;
    logic signed [DATA_W:0]   w_sum;
    logic signed [DATA_W:0]   w_last_ext;
    logic [ADDR_W-1:0]        w_jro;
    logic                     w_unused_const;

    assign w_last = i_len - 1'b1;
    assign w_seq  = (i_pc == w_last) ? '0 : i_pc + 1'b1;
    assign w_tgt  = i_const[ADDR_W-1:0];
    assign w_jmp  = (w_tgt >= i_len) ? '0 : w_tgt;

    assign w_unused_const = ^i_const[DATA_W-1:ADDR_W];

    // One extra bit so pc + src_val cannot overflow before clamping.
    assign w_sum      = $signed({{(DATA_W+1-ADDR_W){1'b0}}, i_pc})
                      + $signed({i_src_val[DATA_W-1], i_src_val});
    assign w_last_ext = $signed({{(DATA_W+1-ADDR_W){1'b0}}, w_last});

    always_comb begin
        w_jro = w_sum[ADDR_W-1:0];
        if (w_sum[DATA_W]) begin
            w_jro = '0;
        end else if (w_sum > w_last_ext) begin
            w_jro = w_last;
        end
    end

    always_comb begin
        o_next = w_seq;
        case (i_pc_instr)
            PC_HOLD: o_next = i_pc;
            PC_JMP,
            PC_JEZ,
            PC_JNZ,
            PC_JGZ,
            PC_JLZ:  o_next = jump_taken(i_pc_instr, i_acc) ? w_jmp : w_seq;
            PC_JRO:  o_next = w_jro;
            default: o_next = w_seq;
        endcase
        if (i_len == '0) begin
            o_next = '0;
        end
    end

endmodule

// File: rtl/tis_pc.sv
// PC stage of a TIS-100 node: IDLE/RUN control, registered pc; next address after 1 cycle.
// stall freezes pc; start restarts at 0. Optional jump counter under TIS_PC_JUMP_CNT_EN.
module tis_pc
    import tis_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [ADDR_W-1:0]        i_prog_len,
    input  logic                     i_stall,
    input  logic [3:0]               i_pc_instr,
    input  logic signed [DATA_W-1:0] i_const,
    input  logic signed [DATA_W-1:0] i_acc,
    input  logic signed [DATA_W-1:0] i_src_val,
    output logic [ADDR_W-1:0]        o_pc,
`ifdef TIS_PC_JUMP_CNT_EN
    output logic [15:0]              o_jump_cnt,
`endif
    output logic                     o_running
);

    pc_state_e         r_state;
    pc_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] w_next;
    logic              w_update;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RUN is only left through reset; start from either state (re)enters RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_update = (r_state == ST_RUN) && !i_stall && !i_start;

    tis_pc_next u_next (
        .i_pc       (r_pc),
        .i_len      (r_len),
        .i_pc_instr (i_pc_instr),
        .i_const    (i_const),
        .i_acc      (i_acc),
        .i_src_val  (i_src_val),
        .o_next     (w_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc  <= '0;
            r_len <= '0;
        end else if (i_start) begin
            r_pc  <= '0;
            r_len <= i_prog_len;
        end else if (w_update) begin
            r_pc  <= w_next;
        end
    end

    assign o_pc      = r_pc;
    assign o_running = (r_state == ST_RUN);

`ifdef TIS_PC_JUMP_CNT_EN
    logic        w_jump;
    logic [15:0] r_jump_cnt;

    // A JRO by zero is a hold, so it does not count as a jump.
    assign w_jump = w_update
                 && (jump_taken(i_pc_instr, i_acc)
                     || ((i_pc_instr == PC_JRO) && (i_src_val != '0)));

    always_ff @(posedge i_clk) begin
        if (i_reset || i_start) begin
            r_jump_cnt <= '0;
        end else if (w_jump && (r_jump_cnt != 16'hFFFF)) begin
            r_jump_cnt <= r_jump_cnt + 16'd1;
        end
    end

    assign o_jump_cnt = r_jump_cnt;
`endif

endmodule

// File: tb/tb_tis_pc.sv
// Bench for tis_pc: directed scenarios with literal expectations plus random traffic
// checked each cycle against an integer-level model of the PC rules.
module tb_tis_pc;

    logic               i_clk;
    logic               i_reset;
    logic               i_start;
    logic [3:0]         i_prog_len;
    logic               i_stall;
    logic [3:0]         i_pc_instr;
    logic signed [10:0] i_const;
    logic signed [10:0] i_acc;
    logic signed [10:0] i_src_val;
    logic [3:0]         o_pc;
    logic               o_running;
`ifdef TIS_PC_JUMP_CNT_EN
    logic [15:0]        o_jump_cnt;
`endif

    tis_pc dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_prog_len (i_prog_len),
        .i_stall    (i_stall),
        .i_pc_instr (i_pc_instr),
        .i_const    (i_const),
        .i_acc      (i_acc),
        .i_src_val  (i_src_val),
        .o_pc       (o_pc),
`ifdef TIS_PC_JUMP_CNT_EN
        .o_jump_cnt (o_jump_cnt),
`endif
        .o_running  (o_running)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    int m_pc  = 0;
    int m_len = 0;
    int m_run = 0;
    int m_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: what one clock edge does to pc / len / run / count given the current inputs.
    task automatic model_step();
        int  op, a, s, t, sum;
        bit  taken, jumped;
        if (i_reset) begin
            m_pc = 0; m_run = 0; m_len = 0; m_cnt = 0;
        end else if (i_start) begin
            m_run = 1; m_len = int'(i_prog_len); m_pc = 0; m_cnt = 0;
        end else if (m_run != 0 && !i_stall) begin
            op = int'(i_pc_instr);
            if (op > 7) op = 0;
            a = int'(i_acc);
            s = int'(i_src_val);
            t = int'(i_const) & 15;
            taken = (op == 2) || (op == 3 && a == 0) || (op == 4 && a != 0)
                 || (op == 5 && a > 0) || (op == 6 && a < 0);
            jumped = taken || (op == 7 && s != 0);
            if (m_len == 0) begin
                m_pc = 0;
            end else if (taken) begin
                m_pc = (t < m_len) ? t : 0;
            end else if (op == 1) begin
                m_pc = m_pc;
            end else if (op == 7) begin
                sum  = m_pc + s;
                m_pc = (sum < 0) ? 0 : ((sum > m_len - 1) ? m_len - 1 : sum);
            end else begin
                m_pc = (m_pc + 1) % m_len;
            end
            if (jumped && m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic cyc(input bit rst, input bit st, input int pl, input bit stl,
                       input int op, input int cn, input int ac, input int sv);
        i_reset    = rst;
        i_start    = st;
        i_prog_len = 4'(pl);
        i_stall    = stl;
        i_pc_instr = 4'(op);
        i_const    = 11'(cn);
        i_acc      = 11'(ac);
        i_src_val  = 11'(sv);
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic op1(input int op, input int cn, input int ac, input int sv);
        cyc(0, 0, 0, 0, op, cn, ac, sv);
    endtask

    always @(negedge i_clk) begin
        if (cmp_en) begin
            check("pc", int'(o_pc), m_pc);
            check("running", int'(o_running), m_run);
`ifdef TIS_PC_JUMP_CNT_EN
            check("jump_cnt", int'(o_jump_cnt), m_cnt);
`endif
        end
    end

    initial begin
        int seq[7];
        int op, ac, sv, r;
        seq = '{0, 1, 2, 3, 4, 0, 1};

        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cmp_en = 1'b1;
        check("reset_pc", int'(o_pc), 0);
        check("reset_running", int'(o_running), 0);

        // Sequential run with wrap at prog_len=5.
        cyc(0, 1, 5, 0, 0, 0, 0, 0);
        check("start_running", int'(o_running), 1);
        check("next_seq_0", int'(o_pc), seq[0]);
        for (int i = 1; i < 7; i++) begin
            op1(0, 0, 0, 0);
            check("next_seq", int'(o_pc), seq[i]);
        end

        // Conditional / absolute jumps at prog_len=8.
        cyc(0, 1, 8, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) op1(0, 0, 0, 0);
        check("at3", int'(o_pc), 3);
        op1(3, 6, 0, 0);
        check("jez_taken", int'(o_pc), 6);
        op1(3, 6, -1, 0);
        check("jez_not_taken", int'(o_pc), 7);
        op1(0, 0, 0, 0);
        check("next_wrap", int'(o_pc), 0);
        op1(2, 12, 0, 0);
        check("jmp_oob", int'(o_pc), 0);

        // Relative jumps with clamping at prog_len=10.
        cyc(0, 1, 10, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) op1(0, 0, 0, 0);
        check("at4", int'(o_pc), 4);
        op1(7, 0, 0, -999);
        check("jro_neg_clamp", int'(o_pc), 0);
        op1(7, 0, 0, 999);
        check("jro_pos_clamp", int'(o_pc), 9);
        op1(7, 0, 0, 0);
        check("jro_zero", int'(o_pc), 9);
        op1(7, 0, 0, -3);
        check("jro_minus3", int'(o_pc), 6);

        // Stall freezes a pending jump.
        cyc(0, 1, 8, 0, 0, 0, 0, 0);
        op1(0, 0, 0, 0);
        op1(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 5, 5, 1, 0);
            check("stall_hold", int'(o_pc), 2);
        end
        op1(5, 5, 1, 0);
        check("jgz_after_stall", int'(o_pc), 5);

        // Reset mid-run under stall, then an empty program.
        cyc(1, 0, 0, 1, 2, 3, 0, 0);
        check("rst_midrun_pc", int'(o_pc), 0);
        check("rst_midrun_running", int'(o_running), 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            op1(i, 9, i - 4, i * 3 - 10);
            check("len0_pc", int'(o_pc), 0);
        end

`ifdef TIS_PC_JUMP_CNT_EN
        cyc(0, 1, 8, 0, 0, 0, 0, 0);
        op1(2, 3, 0, 0);
        op1(4, 1, 0, 0);
        op1(6, 1, -5, 0);
        op1(7, 0, 0, 0);
        op1(7, 0, 0, 2);
        check("jump_cnt_3", int'(o_jump_cnt), 3);
        cyc(0, 1, 8, 0, 0, 0, 0, 0);
        check("jump_cnt_start_clr", int'(o_jump_cnt), 0);
`endif

        // Random traffic; the compare process checks every cycle.
        cyc(0, 1, 12, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 99);
            op = $urandom_range(0, 15);
            ac = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 1998) - 999;
            case ($urandom_range(0, 2))
                0:       sv = 0;
                1:       sv = $urandom_range(0, 40) - 20;
                default: sv = $urandom_range(0, 1998) - 999;
            endcase
            cyc((r == 0), (r >= 1 && r <= 3), $urandom_range(0, 15),
                ($urandom_range(0, 3) == 0), op, $urandom_range(0, 1998) - 999, ac, sv);
        end

        cmp_en = 1'b0;
        @(negedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tis_pc.md
Name: tis_pc

Overview:
- Program-counter stage of a TIS-100 execution node.
- Holds the current instruction address that feeds instruction memory; the memory output drives op_decode.
- Consumes op_decode's pc_instr and const fields, plus the node accumulator and the resolved source operand, to compute the next address each cycle.
- Includes a small IDLE/RUN control FSM and a stall input so I/O port handshakes can freeze the node.

Parameters:
ADDR_W, 4, instruction address width (node program holds at most 2^ADDR_W-1 = 15 lines)
DATA_W, 11, width of const / acc / src_val (signed, two's complement, range -999..999 in use)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: latch prog_len and enter RUN at address 0
prog_len  in  ADDR_W  number of valid program lines (0..15)
stall  in  1  freeze PC for this cycle (port read/write not yet complete)
pc_instr  in  4  PC operation from op_decode
const  in  DATA_W  signed; jump target (low ADDR_W bits) for jump ops
acc  in  DATA_W  signed accumulator value used for conditional jumps
src_val  in  DATA_W  signed resolved source operand, used as the JRO offset
pc  out  ADDR_W  current instruction address
running  out  1  high while in RUN

Behaviour:
- pc_instr encoding:
  - 0 NEXT, 1 HOLD, 2 JMP, 3 JEZ, 4 JNZ, 5 JGZ, 6 JLZ, 7 JRO.
  - 8..15 are reserved and execute as NEXT.
- Reset: pc=0, running=0, FSM=IDLE, latched length len_q=0. Reset has priority over every other input, including mid-RUN and while stall=1.
- FSM:
  - IDLE: pc held at 0. start=1 -> RUN, len_q<=prog_len, pc<=0.
  - RUN: start=1 restarts (len_q re-latched, pc<=0) and has priority over stall and pc_instr.
  - No exit from RUN other than reset.
- Update rule: pc is registered; it updates on the rising edge when state=RUN, stall=0 and start=0. Next-address latency is 1 cycle. stall=1 holds pc unchanged regardless of pc_instr.
- len_q=0: pc stays 0 in RUN for every op.
- NEXT: pc+1; if pc==len_q-1, wrap to 0.
- HOLD: pc unchanged.
- JMP: target t=const[ADDR_W-1:0]. If t>=len_q, go to 0; otherwise go to t.
- Conditional jumps evaluate acc as signed:
  - JEZ taken if acc==0.
  - JNZ taken if acc!=0.
  - JGZ taken if acc>0.
  - JLZ taken if acc<0.
  - Taken: behave as JMP. Not taken: behave as NEXT, including wrap.
- JRO:
  - sum = pc + src_val, computed at DATA_W+1 bits signed.
  - Clamp: sum<0 -> 0; sum>len_q-1 -> len_q-1.
  - JRO with src_val=0 therefore holds.
- pc never reaches a value >= len_q while len_q>0.
- running = (state==RUN), registered.

Optional Feature:
TIS_PC_JUMP_CNT_EN
- Defined:
  - Adds output jump_cnt (16 bits).
  - Counts cycles where an update occurs with JMP, a taken conditional jump, or JRO with nonzero src_val.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by start.
- Undefined: port and counter are absent; there is no other behavioural difference.

Decomposition:
- Package tis_pkg holds:
  - PC_NEXT..PC_JRO localparams (4-bit).
  - Shared widths ADDR_W=4 and DATA_W=11, also used by op_decode.
  - FSM state encoding (IDLE/RUN).
- One combinational sub-module, tis_pc_next, computes the next address.
  - Inputs: pc, len_q, pc_instr, const, acc, src_val.
  - Output: next address.
- tis_pc keeps the FSM, the registers and the optional counter.

Test Plan:
- reset, start with prog_len=5, NEXT every cycle -> pc 0,1,2,3,4,0,1 on successive cycles; running=1 from the cycle after start.
- prog_len=8, pc=3; JEZ const=6 with acc=0 -> pc=6. Then JEZ with acc=-1 -> pc=7. Then NEXT -> pc=0. Then JMP const=12 -> pc=0.
- prog_len=10, pc=4; JRO src_val=-999 -> 0. JRO src_val=+999 -> 9. JRO src_val=0 -> stays 9. JRO src_val=-3 -> 6.
- pc=2, JGZ const=5 acc=1 with stall=1 for 3 cycles -> pc stays 2; first cycle with stall=0 -> pc=5.
- Reset asserted mid-RUN with stall=1 -> next cycle pc=0, running=0. start pulse with prog_len=0, then any ops -> pc remains 0.
- With TIS_PC_JUMP_CNT_EN: JMP, JNZ with acc=0, JLZ with acc=-5, JRO with src_val=0, JRO with src_val=2 -> jump_cnt=3. start pulse -> jump_cnt=0.
